cryptoveril_decrypt: RTL and testbench

Iterative decryptor for the cryptoveril cipher. It takes one 16-bit ciphertext word and the 5-bit key, and returns the matching 16-bit plaintext. It runs the cipher rounds in reverse order, one round per clock. It sits on the receive side of the link, opposite the cryptoveril encryption pipeline, and uses a valid/ready handshake on both sides.

---
 rtl/cryptoveril_pkg.sv | 54 +++++
 rtl/cryptoveril_dec_round.sv | 23 ++
 rtl/cryptoveril_decrypt.sv | 123 ++++++++++++
 tb/tb_cryptoveril_decrypt.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cryptoveril_pkg.sv
// Shared definitions for the cryptoveril cipher: FSM states, the round-key
// helpers (mask/addk) used by both the encryptor and the decryptor, and the
// 16-bit rotate helpers the round datapaths are built from.
package cryptoveril_pkg;

    // Controller states shared by the iterative cipher blocks
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest round count the 3-bit round index can address
    localparam int ROUNDS_MAX = 8;

    localparam int WORD_W = 16;
    localparam int KEY_W  = 5;
    localparam int RIDX_W = 3;

    // Per-round XOR mask: key and round index, repeated twice
    function automatic logic [WORD_W-1:0] mask(input logic [KEY_W-1:0]  k,
                                               input logic [RIDX_W-1:0] r);
        return {k, r, k, r};
    endfunction

    // Additive key: the key zero-padded into each byte
    function automatic logic [WORD_W-1:0] addk(input logic [KEY_W-1:0] k);
        return {3'b000, k, 3'b000, k};
    endfunction

    // Rotate right by 0..15; an amount of 0 leaves the word unchanged
    function automatic logic [WORD_W-1:0] rotr16(input logic [WORD_W-1:0] x,
                                                 input logic [3:0]        amt);
        logic [2*WORD_W-1:0] doubled;
        doubled = {x, x} >> amt;
        return doubled[WORD_W-1:0];
    endfunction

    // Rotate left by 0..15; an amount of 0 leaves the word unchanged
    function automatic logic [WORD_W-1:0] rotl16(input logic [WORD_W-1:0] x,
                                                 input logic [3:0]        amt);
        logic [2*WORD_W-1:0] doubled;
        doubled = {x, x} << amt;
        return doubled[2*WORD_W-1:WORD_W];
    endfunction

    // One forward round, as the encryption pipeline computes it
    function automatic logic [WORD_W-1:0] enc_round(input logic [WORD_W-1:0] x,
                                                    input logic [KEY_W-1:0]  k,
                                                    input logic [RIDX_W-1:0] r);
        return (rotl16(x, k[3:0]) ^ mask(k, r)) + addk(k);
    endfunction

endpackage

// File: rtl/cryptoveril_dec_round.sv
// Single combinational decryption round of the cryptoveril cipher.
// Undoes one encryption round: subtract the additive key (wrapping), strip the
// round mask, then rotate right by the low four key bits.
module cryptoveril_dec_round
    import cryptoveril_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [KEY_W-1:0]  k,
    input  logic [RIDX_W-1:0] r,
    output logic [WORD_W-1:0] x_next
);

    logic [WORD_W-1:0] diff;
    logic [WORD_W-1:0] unmasked;

    // Inverse of (rotl, xor, add) applied in reverse order
    always_comb begin
        diff     = x - addk(k);
        unmasked = diff ^ mask(k, r);
        x_next   = rotr16(unmasked, k[3:0]);
    end

endmodule

// File: rtl/cryptoveril_decrypt.sv
// Iterative cryptoveril decryptor: accepts one ciphertext word with its key,
// runs the rounds from ROUNDS-1 down to 0 at one round per clock, and presents
// the plaintext until the downstream takes it.
// Optional build macro CRYPTOVERIL_DEC_PARITY_EN adds an even-parity input
// (in_par) checked against the ciphertext; otherwise out_err is tied low.
module cryptoveril_decrypt
    import cryptoveril_pkg::*;
#(
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key_bits,
    input  logic [WORD_W-1:0] input_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] output_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
`ifdef CRYPTOVERIL_DEC_PARITY_EN
    input  logic              in_par,
`endif
    output logic              out_err
);

    // First round index processed after a word is accepted
    localparam logic [RIDX_W-1:0] LAST_ROUND = RIDX_W'(ROUNDS - 1);

    state_t            state;
    logic [WORD_W-1:0] data_q;
    logic [KEY_W-1:0]  key_q;
    logic [RIDX_W-1:0] round_q;
    logic [WORD_W-1:0] round_out;
    logic              accept;
    logic              finishing;

    assign accept    = (state == IDLE) && in_valid;
    assign finishing = (state == ROUND) && (round_q == '0);

    // One shared round datapath, fed from the working registers every cycle
    cryptoveril_dec_round u_round (
        .x      (data_q),
        .k      (key_q),
        .r      (round_q),
        .x_next (round_out)
    );

    // Controller: accept, iterate rounds, then hold the result for downstream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            data_q      <= '0;
            key_q       <= '0;
            round_q     <= '0;
            output_data <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= input_data;
                        key_q    <= key_bits;
                        round_q  <= LAST_ROUND;
                        state    <= ROUND;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ROUND: begin
                    data_q <= round_out;
                    if (round_q == '0) begin
                        output_data <= round_out;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        round_q <= round_q - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef CRYPTOVERIL_DEC_PARITY_EN
    logic par_err_q;

    // Parity verdict is taken at accept and only shown while the word is in DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err_q <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (accept) begin
                par_err_q <= ^{input_data, in_par};
            end
            if (finishing) begin
                out_err <= par_err_q;
            end else if ((state == DONE) && out_ready) begin
                out_err <= 1'b0;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_cryptoveril_decrypt.sv
// Self-checking bench for cryptoveril_decrypt. A transaction-level model
// (countdown of rounds plus a bit-serial reference decryptor) predicts the
// handshake outputs every cycle; directed sections pin the documented vectors.
module tb_cryptoveril_decrypt;

    localparam int ROUNDS     = 4;
    localparam int RAND_WORDS = 150;

`ifdef CRYPTOVERIL_DEC_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic [4:0]  key_bits;
    logic [15:0] input_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] output_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        in_par;
    logic        out_err;

    logic [4:0]  d1_key_bits;
    logic [15:0] d1_input_data;
    logic        d1_in_valid;
    logic        d1_in_ready;
    logic [15:0] d1_output_data;
    logic        d1_out_valid;
    logic        d1_out_ready;
    logic        d1_busy;
    logic        d1_out_err;

    int tests = 0;
    int fails = 0;

    int          m_state = 0;
    int          m_left  = 0;
    logic [15:0] m_data  = 16'h0000;
    logic        m_err   = 1'b0;
    int          dut_hs  = 0;
    bit          rand_ready = 1'b0;

    cryptoveril_decrypt #(.ROUNDS(ROUNDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_bits    (key_bits),
        .input_data  (input_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .output_data (output_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
`ifdef CRYPTOVERIL_DEC_PARITY_EN
        .in_par      (in_par),
`endif
        .out_err     (out_err)
    );

`ifdef CRYPTOVERIL_DEC_PARITY_EN
    logic d1_in_par;
    assign d1_in_par = ^d1_input_data;
`endif

    cryptoveril_decrypt #(.ROUNDS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .key_bits    (d1_key_bits),
        .input_data  (d1_input_data),
        .in_valid    (d1_in_valid),
        .in_ready    (d1_in_ready),
        .output_data (d1_output_data),
        .out_valid   (d1_out_valid),
        .out_ready   (d1_out_ready),
        .busy        (d1_busy),
`ifdef CRYPTOVERIL_DEC_PARITY_EN
        .in_par      (d1_in_par),
`endif
        .out_err     (d1_out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decryption straight from the round equations, rotating one bit at a time
    function automatic logic [15:0] model_decrypt(input logic [15:0] ct, input logic [4:0] k,
                                                  input int rounds);
        logic [15:0] x;
        logic [15:0] a;
        logic [15:0] m;
        logic [2:0]  r3;
        x = ct;
        a = {3'b000, k, 3'b000, k};
        for (int r = rounds - 1; r >= 0; r--) begin
            r3 = 3'(r);
            m  = {k, r3, k, r3};
            x  = x - a;
            x  = x ^ m;
            for (int s = 0; s < int'(k[3:0]); s++) x = {x[0], x[15:1]};
        end
        return x;
    endfunction

    // Reference encryption, used only to pin the decryption model by round trip
    function automatic logic [15:0] model_encrypt(input logic [15:0] pt, input logic [4:0] k,
                                                  input int rounds);
        logic [15:0] x;
        logic [2:0]  r3;
        x = pt;
        for (int r = 0; r < rounds; r++) begin
            r3 = 3'(r);
            for (int s = 0; s < int'(k[3:0]); s++) x = {x[14:0], x[15]};
            x = x ^ {k, r3, k, r3};
            x = x + {3'b000, k, 3'b000, k};
        end
        return x;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'd0, actual}, {31'd0, expected});
    endtask

    task automatic checkWord(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
        checkOutput(name, {16'd0, actual}, {16'd0, expected});
    endtask

    // Offer one word once in_ready is seen; returns on the negedge after the accept edge
    task automatic applyStimulus(input logic [15:0] ct, input logic [4:0] k, input logic p);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) checkBit("accept_timeout", in_ready, 1'b1);
        input_data = ct;
        key_bits   = k;
        in_par     = p;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        input_data = 16'($urandom);
        key_bits   = 5'($urandom);
        in_par     = 1'($urandom);
    endtask

    // Counts negedges after the accept edge until out_valid appears (bounded)
    task automatic waitValid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic takeOutput();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic runSingle(input logic [15:0] ct, input logic [4:0] k,
                             input logic [15:0] exp_pt, input string tag);
        int n;
        @(negedge clk);
        checkBit({tag, "_in_ready"}, d1_in_ready, 1'b1);
        d1_input_data = ct;
        d1_key_bits   = k;
        d1_in_valid   = 1'b1;
        @(negedge clk);
        d1_in_valid   = 1'b0;
        n = 0;
        while (!d1_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_latency"}, 32'(n), 32'd1);
        checkWord({tag, "_plaintext"}, d1_output_data, exp_pt);
        checkBit({tag, "_err"}, d1_out_err, 1'b0);
        checkBit({tag, "_busy"}, d1_busy, 1'b1);
        d1_out_ready = 1'b1;
        @(negedge clk);
        d1_out_ready = 1'b0;
        checkBit({tag, "_ready_after"}, d1_in_ready, 1'b1);
        checkBit({tag, "_valid_after"}, d1_out_valid, 1'b0);
    endtask

    // Transaction model: idle / counting rounds / holding result
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state = 0;
            m_left  = 0;
            m_err   = 1'b0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_data  = model_decrypt(input_data, key_bits, ROUNDS);
                    m_err   = PARITY_EN ? (^{input_data, in_par}) : 1'b0;
                    m_left  = ROUNDS;
                    m_state = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) m_state = 2;
                end
                default: if (out_ready) m_state = 0;
            endcase
        end
    end

    // Completed output handshakes seen on the DUT
    always @(posedge clk) begin
        if (rst && out_valid && out_ready) dut_hs++;
    end

    // Random downstream back-pressure while enabled
    always @(negedge clk) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Cycle-by-cycle comparison of the DUT against the transaction model
    always @(negedge clk) begin
        if (rst) begin
            checkBit("in_ready", in_ready, m_state == 0);
            checkBit("busy", busy, m_state != 0);
            checkBit("out_valid", out_valid, m_state == 2);
            if (m_state == 2) begin
                checkWord("output_data", output_data, m_data);
                checkBit("out_err", out_err, m_err);
            end else begin
                checkBit("out_err_idle", out_err, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, tests=%0d", tests);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int hs_base;
        logic [15:0] p;
        logic [4:0]  k;

        rst = 1'b0;
        in_valid = 1'b0; input_data = 16'h0; key_bits = 5'h0; in_par = 1'b0; out_ready = 1'b0;
        d1_in_valid = 1'b0; d1_input_data = 16'h0; d1_key_bits = 5'h0; d1_out_ready = 1'b0;

        checkWord("pin_single", model_decrypt(16'h090B, 5'h01, 1), 16'h0001);
        checkWord("pin_wrap", model_decrypt(16'h0000, 5'h01, 1), 16'hFB7B);
        checkWord("pin_zero_key", model_decrypt(16'hBEEF, 5'h00, 4), 16'hBEEF);
        checkWord("pin_enc", model_encrypt(16'h0001, 5'h01, 1), 16'h090B);
        for (int i = 0; i < 4; i++) begin
            p = 16'($urandom);
            k = 5'($urandom);
            checkWord("pin_roundtrip", model_decrypt(model_encrypt(p, k, ROUNDS), k, ROUNDS), p);
        end

        repeat (3) @(negedge clk);
        checkBit("rst_in_ready", in_ready, 1'b1);
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_out_err", out_err, 1'b0);
        checkWord("rst_output_data", output_data, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        checkBit("post_rst_in_ready", in_ready, 1'b1);

        $display("[TB] single-round vectors");
        runSingle(16'h090B, 5'h01, 16'h0001, "single");
        runSingle(16'h0000, 5'h01, 16'hFB7B, "wrap");

        $display("[TB] zero key, latency and stall");
        applyStimulus(16'hBEEF, 5'h00, 1'b0);
        waitValid(n);
        checkOutput("zero_key_latency", 32'(n), 32'd4);
        checkWord("zero_key_data", output_data, 16'hBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkWord("stall_data", output_data, 16'hBEEF);
            checkBit("stall_valid", out_valid, 1'b1);
            checkBit("stall_in_ready", in_ready, 1'b0);
        end
        takeOutput();
        checkBit("release_in_ready", in_ready, 1'b1);
        checkBit("release_valid", out_valid, 1'b0);

        $display("[TB] input changes while busy");
        applyStimulus(16'h1234, 5'h15, 1'b1);
        for (int i = 0; i < 6; i++) begin
            input_data = 16'($urandom);
            key_bits   = 5'($urandom);
            in_valid   = (i >= 2);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checkBit("keychg_valid", out_valid, 1'b1);
        checkWord("keychg_data", output_data, model_decrypt(16'h1234, 5'h15, ROUNDS));
        takeOutput();

        $display("[TB] reset during rounds");
        applyStimulus(16'hCAFE, 5'h0B, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkBit("abort_in_ready", in_ready, 1'b1);
        checkBit("abort_out_valid", out_valid, 1'b0);
        checkBit("abort_busy", busy, 1'b0);
        checkBit("abort_out_err", out_err, 1'b0);
        checkWord("abort_output_data", output_data, 16'h0000);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(16'h5A5A, 5'h1C, 1'b0);
        waitValid(n);
        checkOutput("after_abort_latency", 32'(n), 32'd4);
        checkWord("after_abort_data", output_data, model_decrypt(16'h5A5A, 5'h1C, ROUNDS));
        takeOutput();

`ifdef CRYPTOVERIL_DEC_PARITY_EN
        $display("[TB] parity flag");
        applyStimulus(16'h0001, 5'h01, 1'b1);
        waitValid(n);
        checkBit("parity_ok_err", out_err, 1'b0);
        takeOutput();
        applyStimulus(16'h0001, 5'h01, 1'b0);
        waitValid(n);
        checkBit("parity_bad_err", out_err, 1'b1);
        checkWord("parity_bad_data", output_data, model_decrypt(16'h0001, 5'h01, ROUNDS));
        takeOutput();
        checkBit("parity_cleared", out_err, 1'b0);
`endif

        $display("[TB] randomized traffic");
        hs_base = dut_hs;
        rand_ready = 1'b1;
        for (int i = 0; i < RAND_WORDS; i++) begin
            applyStimulus(16'($urandom), 5'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checkBit("drain_in_ready", in_ready, 1'b1);
        checkOutput("random_words_done", 32'(dut_hs - hs_base), 32'(RAND_WORDS));

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
